// File: rtl/io_hub.sv
// io_hub: IO-side peer of the CPU.
//
// Decodes the CPU io_* strobes against d_addr[3:0] and d_bus and provides:
//   - a small IO register file (STATUS, PENDING, MASK, RXDATA, TXDATA)
//   - a transmit FIFO (TX_DEPTH words) drained through tx_data/tx_valid/tx_ready
//   - a one-word receive holding register filled through rx_data/rx_valid/rx_ready
//   - a hardware return-address stack (RET_DEPTH words)
//   - an edge-latched, maskable interrupt controller answering io_ints with a vector
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   io_read/io_write  register read / write at d_addr[3:0]
//   io_push           push d_bus into the TX FIFO
//   io_store_retaddr  push d_bus onto the return stack
//   io_read_retaddr   drive the top of the return stack onto d_bus and pop it
//   io_ints           drive the lowest pending+enabled irq index onto d_bus and clear it
//   d_addr            IO address (bits [3:0] decoded)
//   d_bus             shared data bus, driven only while a read strobe is active
//   irq_in            peripheral interrupt request levels
//   int_pending       |(pending & mask)
//   tx_data/tx_valid/tx_ready   TX FIFO head and handshake
//   rx_data/rx_valid/rx_ready   RX holding register load handshake
module io_hub #(
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RET_DEPTH = 8,
    parameter int unsigned NUM_IRQ   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               io_read,
    input  logic               io_write,
    input  logic               io_push,
    input  logic               io_store_retaddr,
    input  logic               io_read_retaddr,
    input  logic               io_ints,
    input  logic [15:0]        d_addr,
    inout  wire  [15:0]        d_bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               int_pending,
    output logic [15:0]        tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [15:0]        rx_data,
    input  logic               rx_valid,
    output logic               rx_ready
);

    localparam int unsigned TPW = $clog2(TX_DEPTH);
    localparam int unsigned TCW = TPW + 1;
    localparam int unsigned RPW = $clog2(RET_DEPTH);
    localparam int unsigned RCW = $clog2(RET_DEPTH + 1);

    typedef enum logic [3:0] {
        REG_STATUS  = 4'd0,
        REG_PENDING = 4'd1,
        REG_MASK    = 4'd2,
        REG_RXDATA  = 4'd3,
        REG_TXDATA  = 4'd4
    } reg_addr_e;

    reg_addr_e addr;
    logic      unused_addr_bits;

    assign addr             = reg_addr_e'(d_addr[3:0]);
    assign unused_addr_bits = ^d_addr[15:4];

    // ------------------------------------------------------------------
    // Read-strobe arbitration: io_ints > io_read_retaddr > io_read
    // ------------------------------------------------------------------
    logic sel_ints, sel_ret, sel_rd;

    assign sel_ints = io_ints;
    assign sel_ret  = io_read_retaddr & ~io_ints;
    assign sel_rd   = io_read & ~io_ints & ~io_read_retaddr;

    logic        bus_en;
    logic [15:0] bus_out;
    logic [15:0] wdata;

    // Write data is the bus value; when this block is itself driving the bus
    // use the internal drive value so writes never depend on tristate readback.
    assign wdata = bus_en ? bus_out : d_bus;
    assign d_bus = bus_en ? bus_out : 'z;

    logic wr_status, wr_pending, wr_mask;

    assign wr_status  = io_write & (addr == REG_STATUS);
    assign wr_pending = io_write & (addr == REG_PENDING);
    assign wr_mask    = io_write & (addr == REG_MASK);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [15:0]    tx_mem [TX_DEPTH];
    logic [TPW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic           tx_push, tx_pop, tx_full, tx_empty, tx_accept, tx_drop;

    assign tx_empty  = (tx_cnt_q == '0);
    assign tx_full   = (tx_cnt_q == TCW'(TX_DEPTH));
    assign tx_push   = io_push | (io_write & (addr == REG_TXDATA));
    assign tx_pop    = ~tx_empty & tx_ready;
    assign tx_accept = tx_push & (~tx_full | tx_pop);
    assign tx_drop   = tx_push & tx_full & ~tx_pop;

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_accept) tx_wr_d = tx_wr_q + TPW'(1);
        if (tx_pop)    tx_rd_d = tx_rd_q + TPW'(1);
        case ({tx_accept, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + TCW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - TCW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_accept) tx_mem[tx_wr_q] <= wdata;
    end

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_mem[tx_rd_q];

    // ------------------------------------------------------------------
    // RX holding register
    // ------------------------------------------------------------------
    logic        rx_full_q, rx_full_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_load, rx_take;

    assign rx_load = rx_valid & ~rx_full_q;
    assign rx_take = sel_rd & (addr == REG_RXDATA) & rx_full_q;

    always_comb begin
        rx_full_d = rx_full_q;
        rx_data_d = rx_data_q;
        if (rx_load) begin
            rx_full_d = 1'b1;
            rx_data_d = rx_data;
        end else if (rx_take) begin
            rx_full_d = 1'b0;
        end
    end

    assign rx_ready = ~rx_full_q;

    // ------------------------------------------------------------------
    // Return-address stack
    // ------------------------------------------------------------------
    logic [15:0]    ret_mem [RET_DEPTH];
    logic [RCW-1:0] ret_cnt_q, ret_cnt_d;
    logic [RPW-1:0] ret_top_idx, ret_wr_idx;
    logic           ret_wr_en, ret_empty, ret_full;
    logic           ret_ovf_set, ret_unf_set;

    assign ret_empty   = (ret_cnt_q == '0);
    assign ret_full    = (ret_cnt_q == RCW'(RET_DEPTH));
    assign ret_top_idx = RPW'(ret_cnt_q - RCW'(1));

    always_comb begin
        ret_cnt_d   = ret_cnt_q;
        ret_wr_en   = 1'b0;
        ret_wr_idx  = RPW'(ret_cnt_q);
        ret_ovf_set = 1'b0;
        ret_unf_set = 1'b0;
        if (io_store_retaddr && sel_ret) begin
            // Push+pop: the old top is shown on the bus and overwritten in place.
            ret_wr_en = 1'b1;
            if (ret_empty) begin
                ret_unf_set = 1'b1;
                ret_wr_idx  = '0;
                ret_cnt_d   = RCW'(1);
            end else begin
                ret_wr_idx = ret_top_idx;
            end
        end else if (io_store_retaddr) begin
            if (ret_full) begin
                ret_ovf_set = 1'b1;
            end else begin
                ret_wr_en = 1'b1;
                ret_cnt_d = ret_cnt_q + RCW'(1);
            end
        end else if (sel_ret) begin
            if (ret_empty) ret_unf_set = 1'b1;
            else           ret_cnt_d   = ret_cnt_q - RCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ret_wr_en) ret_mem[ret_wr_idx] <= wdata;
    end

    // ------------------------------------------------------------------
    // Interrupt controller
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] irq_d_q, pending_q, pending_d, mask_q, mask_d;
    logic [NUM_IRQ-1:0] irq_act, irq_ack, pending_clr;
    logic [15:0]        irq_vec;
    logic               irq_found;

    assign irq_act = pending_q & mask_q;

    always_comb begin
        irq_found = 1'b0;
        irq_vec   = 16'hFFFF;
        irq_ack   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!irq_found && irq_act[i]) begin
                irq_found  = 1'b1;
                irq_vec    = 16'(i);
                irq_ack[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pending_clr = '0;
        if (sel_ints)   pending_clr = pending_clr | irq_ack;
        if (wr_pending) pending_clr = pending_clr | wdata[NUM_IRQ-1:0];
        // A new rising edge overrides a clear in the same cycle.
        pending_d = (pending_q & ~pending_clr) | (irq_in & ~irq_d_q);
        mask_d    = wr_mask ? wdata[NUM_IRQ-1:0] : mask_q;
    end

    assign int_pending = |irq_act;

    // ------------------------------------------------------------------
    // Sticky flags (a set in the same cycle as a clear wins)
    // ------------------------------------------------------------------
    logic       tx_ovf_q, tx_ovf_d, ret_ovf_q, ret_ovf_d, ret_unf_q, ret_unf_d;
    logic [2:0] sticky_clr;

    always_comb begin
        sticky_clr = wr_status ? wdata[5:3] : 3'b000;
        tx_ovf_d   = (tx_ovf_q  & ~sticky_clr[0]) | tx_drop;
        ret_ovf_d  = (ret_ovf_q & ~sticky_clr[1]) | ret_ovf_set;
        ret_unf_d  = (ret_unf_q & ~sticky_clr[2]) | ret_unf_set;
    end

    // ------------------------------------------------------------------
    // Register read mux and bus drive
    // ------------------------------------------------------------------
    logic [15:0] status, reg_rd;

    always_comb begin
        status        = '0;
        status[0]     = tx_empty;
        status[1]     = tx_full;
        status[2]     = rx_full_q;
        status[3]     = tx_ovf_q;
        status[4]     = ret_ovf_q;
        status[5]     = ret_unf_q;
        status[6]     = int_pending;
        status[11:8]  = 4'(ret_cnt_q);
    end

    always_comb begin
        reg_rd = '0;
        case (addr)
            REG_STATUS:  reg_rd = status;
            REG_PENDING: reg_rd[NUM_IRQ-1:0] = pending_q;
            REG_MASK:    reg_rd[NUM_IRQ-1:0] = mask_q;
            REG_RXDATA:  reg_rd = rx_full_q ? rx_data_q : '0;
            default:     reg_rd = '0;
        endcase
    end

    always_comb begin
        bus_en  = sel_ints | sel_ret | sel_rd;
        bus_out = '0;
        if (sel_ints)     bus_out = irq_vec;
        else if (sel_ret) bus_out = ret_empty ? '0 : ret_mem[ret_top_idx];
        else if (sel_rd)  bus_out = reg_rd;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            rx_full_q <= 1'b0;
            rx_data_q <= '0;
            ret_cnt_q <= '0;
            irq_d_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            tx_ovf_q  <= 1'b0;
            ret_ovf_q <= 1'b0;
            ret_unf_q <= 1'b0;
        end else begin
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_full_q <= rx_full_d;
            rx_data_q <= rx_data_d;
            ret_cnt_q <= ret_cnt_d;
            irq_d_q   <= irq_in;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            tx_ovf_q  <= tx_ovf_d;
            ret_ovf_q <= ret_ovf_d;
            ret_unf_q <= ret_unf_d;
        end
    end

endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: a queue-based behavioural model plus
// directed vectors with hand-computed expectations.
module tb_io_hub;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_read, io_write, io_push, io_store_retaddr, io_read_retaddr, io_ints;
    logic [15:0] d_addr;
    logic        tb_en;
    logic [15:0] tb_val;
    wire  [15:0] d_bus;
    logic [7:0]  irq_in;
    logic        int_pending;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    assign d_bus = tb_en ? tb_val : 'z;

    io_hub #(.TX_DEPTH(16), .RET_DEPTH(8), .NUM_IRQ(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .io_read          (io_read),
        .io_write         (io_write),
        .io_push          (io_push),
        .io_store_retaddr (io_store_retaddr),
        .io_read_retaddr  (io_read_retaddr),
        .io_ints          (io_ints),
        .d_addr           (d_addr),
        .d_bus            (d_bus),
        .irq_in           (irq_in),
        .int_pending      (int_pending),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [15:0] m_tx[$];
    logic [15:0] m_ret[$];
    logic        m_tx_ovf, m_ret_ovf, m_ret_unf, m_rx_full;
    logic [15:0] m_rx;
    logic [7:0]  m_pend, m_mask, m_prev;
    bit          live = 0;

    function automatic logic [15:0] m_lowest();
        for (int i = 0; i < 8; i++)
            if (m_pend[i] && m_mask[i]) return 16'(i);
        return 16'hFFFF;
    endfunction

    function automatic logic [15:0] m_reg(input logic [3:0] a);
        logic [15:0] s;
        s = 16'h0000;
        case (a)
            4'd0: begin
                s[0]    = (m_tx.size() == 0);
                s[1]    = (m_tx.size() == 16);
                s[2]    = m_rx_full;
                s[3]    = m_tx_ovf;
                s[4]    = m_ret_ovf;
                s[5]    = m_ret_unf;
                s[6]    = |(m_pend & m_mask);
                s[11:8] = 4'(m_ret.size());
            end
            4'd1:    s = {8'h00, m_pend};
            4'd2:    s = {8'h00, m_mask};
            4'd3:    s = m_rx_full ? m_rx : 16'h0000;
            default: s = 16'h0000;
        endcase
        return s;
    endfunction

    function automatic bit m_drv_active();
        return io_ints || io_read_retaddr || io_read;
    endfunction

    function automatic logic [15:0] m_drive();
        if (io_ints) return m_lowest();
        if (io_read_retaddr) return (m_ret.size() == 0) ? 16'h0000 : m_ret[m_ret.size()-1];
        return m_reg(d_addr[3:0]);
    endfunction

    always @(posedge clk) begin : model_upd
        logic [15:0] w, lv;
        logic [7:0]  clr;
        logic [3:0]  a;
        logic        ev_txovf, ev_retovf, ev_retunf, rx_load, tx_pop;
        if (rst) begin
            m_tx.delete();
            m_ret.delete();
            m_tx_ovf = 0; m_ret_ovf = 0; m_ret_unf = 0; m_rx_full = 0; m_rx = 0;
            m_pend = 0; m_mask = 0; m_prev = 0;
            live = 1;
        end else if (live) begin
            w  = m_drv_active() ? m_drive() : tb_val;
            a  = d_addr[3:0];
            clr = 8'h00;
            ev_txovf = 0; ev_retovf = 0; ev_retunf = 0;
            rx_load = rx_valid && !m_rx_full;
            tx_pop  = (m_tx.size() != 0) && tx_ready;
            if (io_ints) begin
                lv = m_lowest();
                if (lv != 16'hFFFF) clr[lv[2:0]] = 1'b1;
            end else if (io_read_retaddr) begin
                if (m_ret.size() == 0) ev_retunf = 1;
                else void'(m_ret.pop_back());
            end else if (io_read && a == 4'd3 && m_rx_full) begin
                m_rx_full = 0;
            end
            if (rx_load) begin
                m_rx_full = 1;
                m_rx = rx_data;
            end
            if (tx_pop) void'(m_tx.pop_front());
            if (io_push || (io_write && a == 4'd4)) begin
                if (m_tx.size() < 16) m_tx.push_back(w);
                else ev_txovf = 1;
            end
            if (io_store_retaddr) begin
                if (m_ret.size() < 8) m_ret.push_back(w);
                else ev_retovf = 1;
            end
            if (io_write && a == 4'd0) begin
                if (w[3]) m_tx_ovf = 0;
                if (w[4]) m_ret_ovf = 0;
                if (w[5]) m_ret_unf = 0;
            end
            if (io_write && a == 4'd1) clr = clr | w[7:0];
            if (io_write && a == 4'd2) m_mask = w[7:0];
            m_tx_ovf  = m_tx_ovf  | ev_txovf;
            m_ret_ovf = m_ret_ovf | ev_retovf;
            m_ret_unf = m_ret_unf | ev_retunf;
            m_pend = (m_pend & ~clr) | (irq_in & ~m_prev);
            m_prev = irq_in;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (live) begin
            chk("tx_valid", 16'(tx_valid), 16'(m_tx.size() != 0));
            chk("tx_data", tx_data, (m_tx.size() != 0) ? m_tx[0] : 16'h0000);
            chk("rx_ready", 16'(rx_ready), 16'(!m_rx_full));
            chk("int_pending", 16'(int_pending), 16'(|(m_pend & m_mask)));
            if (m_drv_active()) chk("d_bus", d_bus, m_drive());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [15:0] v;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] val);
        io_read = 1; d_addr = {12'h000, a};
        @(negedge clk); val = d_bus;
        step(); io_read = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] dat);
        io_write = 1; d_addr = {12'h000, a}; tb_en = 1; tb_val = dat;
        step(); io_write = 0; tb_en = 0;
    endtask

    task automatic push(input logic [15:0] dat);
        io_push = 1; tb_en = 1; tb_val = dat;
        step(); io_push = 0; tb_en = 0;
    endtask

    task automatic store(input logic [15:0] dat);
        io_store_retaddr = 1; tb_en = 1; tb_val = dat;
        step(); io_store_retaddr = 0; tb_en = 0;
    endtask

    task automatic retrd(output logic [15:0] val);
        io_read_retaddr = 1;
        @(negedge clk); val = d_bus;
        step(); io_read_retaddr = 0;
    endtask

    task automatic ints(output logic [15:0] val);
        io_ints = 1;
        @(negedge clk); val = d_bus;
        step(); io_ints = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; io_read = 0; io_write = 0; io_push = 0; io_store_retaddr = 0;
        io_read_retaddr = 0; io_ints = 0; d_addr = 0; tb_en = 0; tb_val = 0;
        irq_in = 0; tx_ready = 0; rx_data = 0; rx_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        @(negedge clk);
        chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
        chk("rst_rx_ready", 16'(rx_ready), 16'h0001);
        chk("rst_int_pending", 16'(int_pending), 16'h0000);
        chk("rst_tx_data", tx_data, 16'h0000);
        step();
        rd(4'd0, v); chk("status_idle", v, 16'h0001);

        // TX ordering
        push(16'hA5A5);
        wr(4'd4, 16'h1234);
        @(negedge clk); chk("tx_head_hold", tx_data, 16'hA5A5);
        step();
        tx_ready = 1;
        @(negedge clk); chk("tx_first", tx_data, 16'hA5A5);
        step();
        @(negedge clk); chk("tx_second", tx_data, 16'h1234);
        step();
        @(negedge clk); chk("tx_drained", 16'(tx_valid), 16'h0000);
        step();
        tx_ready = 0;

        // io_push and TXDATA write together are one push
        io_push = 1; io_write = 1; d_addr = 16'h0004; tb_en = 1; tb_val = 16'h7777;
        step();
        io_push = 0; io_write = 0; tb_en = 0;
        @(negedge clk); chk("dual_push_head", tx_data, 16'h7777);
        step();
        tx_ready = 1;
        step();
        tx_ready = 0;
        @(negedge clk); chk("dual_push_single", 16'(tx_valid), 16'h0000);
        step();

        // TX overflow and clear
        for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i));
        push(16'hDEAD);
        rd(4'd0, v); chk("status_txovf", v, 16'h000A);
        wr(4'd0, 16'h0008);
        rd(4'd0, v); chk("status_txovf_clr", v, 16'h0002);
        // Full with simultaneous pop accepts the push
        tx_ready = 1;
        push(16'hBEEF);
        repeat (15) step();
        @(negedge clk); chk("full_pop_push", tx_data, 16'hBEEF);
        step();
        tx_ready = 0;
        @(negedge clk); chk("tx_empty_again", 16'(tx_valid), 16'h0000);
        step();
        rd(4'd0, v); chk("status_no_ovf", v, 16'h0001);

        // RX holding register
        rx_data = 16'hCAFE; rx_valid = 1;
        step();
        rx_data = 16'hBEEF;
        @(negedge clk); chk("rx_full_ready", 16'(rx_ready), 16'h0000);
        step();
        rx_valid = 0;
        rd(4'd0, v); chk("status_rxfull", v, 16'h0005);
        rd(4'd3, v); chk("rx_read", v, 16'hCAFE);
        rd(4'd3, v); chk("rx_read_empty", v, 16'h0000);

        // Return stack
        store(16'h0100);
        store(16'h0200);
        retrd(v); chk("ret_pop1", v, 16'h0200);
        retrd(v); chk("ret_pop2", v, 16'h0100);
        retrd(v); chk("ret_unf_val", v, 16'h0000);
        rd(4'd0, v); chk("status_retunf", v, 16'h0021);
        wr(4'd0, 16'h0020);
        for (int i = 1; i <= 9; i++) store(16'h1000 + 16'(i));
        rd(4'd0, v); chk("status_retovf", v, 16'h0811);
        retrd(v); chk("ret_top_after_ovf", v, 16'h1008);
        wr(4'd0, 16'h0010);
        io_store_retaddr = 1; io_read_retaddr = 1;
        @(negedge clk); chk("ret_pushpop", d_bus, 16'h1007);
        step();
        io_store_retaddr = 0; io_read_retaddr = 0;
        rd(4'd0, v); chk("ret_pushpop_count", v, 16'h0701);
        repeat (7) retrd(v);
        io_store_retaddr = 1; io_read_retaddr = 1;
        @(negedge clk); chk("ret_pushpop_empty", d_bus, 16'h0000);
        step();
        io_store_retaddr = 0; io_read_retaddr = 0;
        rd(4'd0, v); chk("status_pushpop_empty", v, 16'h0121);
        retrd(v); chk("ret_empty_pushed", v, 16'h0000);
        wr(4'd0, 16'h0020);

        // Interrupts
        wr(4'd2, 16'h0006);
        rd(4'd2, v); chk("mask_read", v, 16'h0006);
        irq_in = 8'h06;
        step();
        irq_in = 8'h00;
        @(negedge clk); chk("int_pending_set", 16'(int_pending), 16'h0001);
        step();
        rd(4'd1, v); chk("pending_read", v, 16'h0006);
        ints(v); chk("ints_vec1", v, 16'h0001);
        ints(v); chk("ints_vec2", v, 16'h0002);
        ints(v); chk("ints_none", v, 16'hFFFF);
        @(negedge clk); chk("int_pending_clr", 16'(int_pending), 16'h0000);
        step();
        irq_in = 8'h01;
        step();
        irq_in = 8'h00;
        step();
        rd(4'd1, v); chk("pending_masked", v, 16'h0001);
        irq_in = 8'h01;
        wr(4'd1, 16'h0001);
        rd(4'd1, v); chk("pend_set_wins", v, 16'h0001);
        wr(4'd1, 16'h0001);
        rd(4'd1, v); chk("pend_w1c", v, 16'h0000);
        irq_in = 8'h00;

        // Drive priority: io_ints wins over retaddr and register reads
        store(16'h5555);
        irq_in = 8'h02;
        step();
        irq_in = 8'h00;
        io_ints = 1; io_read_retaddr = 1; io_read = 1; d_addr = 16'h0003;
        @(negedge clk); chk("prio_ints", d_bus, 16'h0001);
        step();
        io_ints = 0; io_read_retaddr = 0; io_read = 0;
        rd(4'd0, v); chk("prio_no_pop", v, 16'h0101);
        retrd(v); chk("prio_ret_kept", v, 16'h5555);

        // Reset has priority over a strobe
        rst = 1; io_push = 1; tb_en = 1; tb_val = 16'h1111;
        step();
        rst = 0; io_push = 0; tb_en = 0;
        @(negedge clk); chk("rst_prio", 16'(tx_valid), 16'h0000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_hub.md
Name: io_hub

Overview:
- IO-side peer of the CPU. It consumes the CPU's io_* strobes, d_addr and d_bus.
- Provides a small IO register file, a transmit FIFO fed by io_push, and a one-word receive holding register.
- Provides a hardware return-address stack served by io_store_retaddr and io_read_retaddr.
- Provides an edge-latched interrupt controller that answers io_ints with a vector on d_bus.

Parameters:
- TX_DEPTH, 16, transmit FIFO depth in words; power of 2, between 2 and 256.
- RET_DEPTH, 8, return-address stack depth in words; power of 2, between 2 and 15.
- NUM_IRQ, 8, number of peripheral interrupt lines; between 1 and 16.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- io_read  in  1  read the IO register selected by d_addr[3:0].
- io_write  in  1  write d_bus to the IO register selected by d_addr[3:0].
- io_push  in  1  push d_bus into the TX FIFO.
- io_store_retaddr  in  1  push d_bus onto the return-address stack.
- io_read_retaddr  in  1  drive the top of the stack onto d_bus and pop it.
- io_ints  in  1  interrupt acknowledge: drive the vector onto d_bus and clear that pending bit.
- d_addr  in  16  IO address; only bits [3:0] are decoded.
- d_bus  inout  16  shared data bus; driven only while this block is reading, otherwise Z.
- irq_in  in  NUM_IRQ  peripheral interrupt request levels.
- int_pending  out  1  |(pending & mask).
- tx_data  out  16  head of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  consumer takes tx_data when tx_valid && tx_ready.
- rx_data  in  16  receive word from the peripheral.
- rx_valid  in  1  receive word offered.
- rx_ready  out  1  equals !rx_full.

Behaviour:
- Reset (rst=1 at a clock edge):
  - TX FIFO, return stack and RX holding register are emptied.
  - pending, mask, sticky flags and the irq edge-detect register are all cleared to 0.
  - Outputs after reset: int_pending=0, tx_valid=0, rx_ready=1, tx_data=0, d_bus=Z.
  - rst has priority over every strobe in the same cycle.
- Read path:
  - Combinational, zero latency: d_bus is valid in the same cycle as the strobe.
  - Side effects (pops, clears) take place at the next rising edge.
- Drive priority when strobes overlap: io_ints, then io_read_retaddr, then io_read. Only the winning strobe's side effect occurs.
- Write-type strobes (io_write, io_push, io_store_retaddr) act independently and may coincide with each other.
- Register map for io_read/io_write, selected by d_addr[3:0]:
  - 0 STATUS (read):
    - [0] tx_empty, [1] tx_full, [2] rx_full.
    - [3] tx_ovf, [4] ret_ovf, [5] ret_unf.
    - [6] int_pending, [7] 0.
    - [11:8] return-stack count, [15:12] 0.
    - Write: 1s in bits [5:3] clear the matching sticky flags; all other bits are ignored.
  - 1 PENDING (read): pending, zero-extended. Write: write-1-to-clear.
  - 2 MASK: read/write, NUM_IRQ bits, zero-extended.
  - 3 RXDATA (read): returns the holding register and clears rx_full. Returns 0 if empty, with no side effect.
  - 4 TXDATA (write): same effect as io_push.
  - 5..15: read 0; writes are ignored.
- TX FIFO:
  - Push when io_push, or io_write to address 4. Both in one cycle count as one push.
  - If full and no pop occurs in the same cycle: the word is dropped and tx_ovf is set.
  - If full with a simultaneous pop: the push is accepted.
  - Pointers wrap modulo TX_DEPTH. A count register distinguishes full from empty.
- RX: the holding register is loaded when rx_valid && rx_ready. rx_full is set on load and cleared by a read of address 3.
- Return stack (LIFO):
  - Push while count==RET_DEPTH: the word is dropped and ret_ovf is set.
  - Pop while empty: d_bus is driven 0 and ret_unf is set.
  - A push and a pop in the same cycle: d_bus shows the old top, which is then replaced by the pushed word; count is unchanged.
  - When empty, the same push+pop drives 0, sets ret_unf, and the word is pushed (count goes 0 to 1).
- Interrupts:
  - irq_d is irq_in registered.
  - pending[i] is set on a rising edge (irq_in[i] & ~irq_d[i]).
  - If a set and a clear of the same bit fall in one cycle, the set wins.
  - io_ints drives the index of the lowest-numbered set bit of (pending & mask) on d_bus[15:0], and clears that bit.
  - If none is set, io_ints drives 16'hFFFF with no side effect.
  - int_pending is registered-state combinational: it updates the cycle after pending or mask changes.

Test Plan:
- Reset, then idle: d_bus=Z, tx_valid=0, rx_ready=1, int_pending=0, STATUS read = 16'h0001.
- Push 16'hA5A5 then 16'h1234 with tx_ready=0 -> tx_data=A5A5. Raise tx_ready -> A5A5 and 1234 are delivered in order, then tx_valid=0.
- Fill the TX FIFO to 16 words, push 17th (16'hDEAD) -> dropped, STATUS[3]=1. Write STATUS 16'h0008 -> bit 3 cleared.
- Store retaddr 16'h0100, 16'h0200; read_retaddr twice -> 0200 then 0100. A third read -> 0, STATUS[5]=1, count=0.
- Push 9 return addresses with RET_DEPTH=8 -> ret_ovf set, count=8, top equals the 8th word.
- MASK=16'h0006; pulse irq_in[1] and irq_in[2] in the same cycle -> int_pending=1. io_ints -> d_bus=1; next io_ints -> 2; next io_ints -> 16'hFFFF, int_pending=0.
